rv32i_test_ctrl: RTL
====================

Name: rv32i_test_ctrl

Overview:
Synthesizable test controller for the rv32i core. It streams images into instruction memory, data memory and the register file, holds the core in reset during loading, then releases it. It watches the PC for a halt loop, enforces a cycle budget, samples x1 and reports pass/fail/timeout. It is the parametrised, self-checking replacement for ad-hoc bench loading and fixed-time finish, and it is usable on FPGA as well as in simulation.

Parameters:
XLEN, 32, data/PC width
IM_AW, 8, instruction-memory word-address width
DM_AW, 8, data-memory word-address width
RF_AW, 5, register-file index width
MAX_CYCLES, 35, run budget in core cycles; counter width is clog2(MAX_CYCLES+1)
STALL_LIMIT, 4, consecutive cycles with unchanged PC that count as a halt (jal x0,0); minimum 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  pulse in IDLE: run with current memory contents, no load
ld_valid  in  1  load beat valid
ld_ready  out  1  load beat accepted when valid&ready
ld_target  in  2  0=IM, 1=DM, 2=RF, 3=reserved
ld_addr  in  IM_AW max DM_AW  word address or register index (LSBs used)
ld_data  in  XLEN  write data
ld_last  in  1  final beat of the image
im_we, dm_we, rf_we  out  1 each  write strobes to the core memories
wr_addr  out  max(IM_AW,DM_AW)  shared write address
wr_data  out  XLEN  shared write data
core_rst_n  out  1  core reset; low holds PC at 0
core_run  out  1  core clock enable
core_pc  in  XLEN  core PC observation
core_x1  in  XLEN  x1 observation
expect_val  in  XLEN  expected x1 at halt
clear  in  1  pulse in DONE: return to IDLE
done, halted, timeout, pass, ld_err  out  1 each  status
result  out  XLEN  x1 captured at exit
cycles  out  clog2(MAX_CYCLES+1)  run cycles consumed

Behaviour:
- Clock is clk; reset is synchronous, active-low, port rst_n. No other clock.
- While rst_n=0 at a clock edge: state goes to IDLE. All strobes, status, result and cycles go to 0. core_rst_n=0, core_run=0. ld_ready is 0 while rst_n is low. Any in-flight load beat is dropped with no strobe.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: ld_ready=1, core_rst_n=0.
  - An accepted beat goes to LOAD, or to RUN if ld_last=1.
  - start=1 with no beat goes to RUN.
  - A beat and start in the same cycle: the beat wins and start is ignored.
- LOAD: ld_ready=1, core_rst_n=0. Each accepted beat asserts exactly one strobe, selected by ld_target, for one cycle on the edge after acceptance. wr_addr/wr_data are registered with the strobe. Beats are accepted back-to-back (one per cycle).
- ld_target=3: the beat is accepted, no strobe fires, and ld_err sets sticky until the next IDLE entry.
- ld_last beat: its strobe fires on the same edge the FSM enters RUN.
- RF beats with index 0 are written anyway; the core ignores writes to x0.
- RUN: core_rst_n=1, core_run=1, ld_ready=0. cycles increments once per RUN cycle, counting the entry cycle as 1.
- Halt detection: compare core_pc to the previous cycle's core_pc.
  - The stall count increments on a match and clears to 0 on a mismatch.
  - It is not evaluated on the first RUN cycle.
  - stall count == STALL_LIMIT-1 on a match means halted.
- Timeout occurs when cycles == MAX_CYCLES and no halt was detected that cycle. Halt and timeout in the same cycle: halted=1, timeout=0.
- On exit to DONE:
  - result <= core_x1
  - pass <= halted && (core_x1 == expect_val)
  - done=1
  - core_run=0 (core frozen, not reset)
- DONE: all status holds. ld_valid is ignored (ld_ready=0), and start is ignored. clear returns to IDLE, which zeroes the status, cycles and ld_err. clear in any other state is ignored.
- The cycles counter saturates at MAX_CYCLES and never wraps.
- rst_n low mid-RUN: immediate IDLE, core_rst_n=0, no result latched.

Decomposition:
- Package rv32i_test_pkg holds:
  - state enum (IDLE/LOAD/RUN/DONE)
  - target codes TGT_IM=0, TGT_DM=1, TGT_RF=2, TGT_RSV=3
  - default MAX_CYCLES/STALL_LIMIT constants
- One sub-module, rv32i_halt_detect: core_pc in, stall counter, halted pulse out, STALL_LIMIT parameter.
- Load path and FSM stay in the top.

Test Plan:
- Load 3 IM words (addr 0..2, last on addr 2), expect_val=0x0000000A, program ends in jal x0,0 at addr 2 -> one strobe per beat; done=1, halted=1, pass=1, result=0x0000000A, timeout=0.
- Same program with expect_val=0x0000000B -> halted=1, pass=0, result=0x0000000A.
- Program that never repeats its PC, MAX_CYCLES=35 -> done on RUN cycle 35, cycles=35, timeout=1, pass=0.
- Beat with ld_target=3, then a valid IM beat with last -> no strobe for the first beat, ld_err=1 held through DONE, cleared after clear.
- rst_n low on RUN cycle 10 -> next edge: IDLE, core_rst_n=0, done=0, cycles=0; start then reruns from PC 0.
- Halt exactly on cycle MAX_CYCLES (STALL_LIMIT=2) -> halted=1, timeout=0.

Source files
------------

// File: rtl/rv32i_test_pkg.sv
// rv32i_test_pkg: controller states, load-target codes and default run limits
package rv32i_test_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [1:0] TGT_IM  = 2'd0;
    localparam logic [1:0] TGT_DM  = 2'd1;
    localparam logic [1:0] TGT_RF  = 2'd2;
    localparam logic [1:0] TGT_RSV = 2'd3;
    localparam int DEF_MAX_CYCLES  = 35;
    localparam int DEF_STALL_LIMIT = 4;
endpackage

// File: rtl/rv32i_halt_detect.sv
// rv32i_halt_detect: flags a halt once the PC has repeated for STALL_LIMIT consecutive run cycles
module rv32i_halt_detect
    import rv32i_test_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            first,
    input  logic [XLEN-1:0] core_pc,
    output logic            hit
);
    localparam int SW = $clog2(STALL_LIMIT);
    logic [XLEN-1:0] prev_pc;
    logic [SW-1:0]   stall;
    logic            match;
    assign match = en && !first && core_pc == prev_pc;
    assign hit   = match && stall == SW'(STALL_LIMIT - 1);
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            prev_pc <= '0;
            stall   <= '0;
        end else begin
            prev_pc <= core_pc;
            stall   <= match ? (hit ? stall : stall + 1'b1) : '0;
        end
    end
endmodule

// File: rtl/rv32i_test_ctrl.sv
// rv32i_test_ctrl: streams images into the core memories, runs the core and reports halt/timeout/pass
module rv32i_test_ctrl
    import rv32i_test_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int IM_AW       = 8,
    parameter int DM_AW       = 8,
    parameter int RF_AW       = 5,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    localparam int AW = (IM_AW > DM_AW) ? IM_AW : DM_AW,
    localparam int CW = $clog2(MAX_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [1:0]      ld_target,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_last,
    output logic            im_we,
    output logic            dm_we,
    output logic            rf_we,
    output logic [AW-1:0]   wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic            core_rst_n,
    output logic            core_run,
    input  logic [XLEN-1:0] core_pc,
    input  logic [XLEN-1:0] core_x1,
    input  logic [XLEN-1:0] expect_val,
    input  logic            clear,
    output logic            done,
    output logic            halted,
    output logic            timeout,
    output logic            pass,
    output logic            ld_err,
    output logic [XLEN-1:0] result,
    output logic [CW-1:0]   cycles
);
    state_t        state, nxt;
    logic          acc, hit, first, tmo, cap;
    logic [CW-1:0] cnt;
    assign ld_ready   = rst_n && (state == IDLE || state == LOAD);
    assign core_rst_n = state == RUN || state == DONE;
    assign core_run   = state == RUN;
    assign acc        = ld_valid && ld_ready;
    assign first      = state == RUN && cycles == '0;
    assign cnt        = cycles + 1'b1;
    assign tmo        = state == RUN && cnt == CW'(MAX_CYCLES);
    assign cap        = state == RUN && (hit || tmo);
    rv32i_halt_detect #(.XLEN(XLEN), .STALL_LIMIT(STALL_LIMIT)) u_halt (
        .clk(clk), .rst_n(rst_n), .en(state == RUN), .first(first), .core_pc(core_pc), .hit(hit)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = acc ? (ld_last ? RUN : LOAD) : (start ? RUN : IDLE);
            LOAD:    nxt = (acc && ld_last) ? RUN : LOAD;
            RUN:     nxt = cap ? DONE : RUN;
            default: nxt = clear ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {im_we, dm_we, rf_we} <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            {done, halted, timeout, pass, ld_err} <= '0;
            result  <= '0;
            cycles  <= '0;
        end else begin
            im_we <= acc && ld_target == TGT_IM;
            dm_we <= acc && ld_target == TGT_DM;
            rf_we <= acc && ld_target == TGT_RF;
            if (acc) begin
                wr_addr <= ld_target == TGT_RF ? AW'(ld_addr[RF_AW-1:0]) :
                           ld_target == TGT_IM ? AW'(ld_addr[IM_AW-1:0]) : AW'(ld_addr[DM_AW-1:0]);
                wr_data <= ld_data;
            end
            if (acc && ld_target == TGT_RSV) ld_err <= 1'b1;
            if (state == RUN) cycles <= cycles == CW'(MAX_CYCLES) ? cycles : cnt;
            if (cap) begin
                done    <= 1'b1;
                halted  <= hit;
                timeout <= !hit;
                pass    <= hit && core_x1 == expect_val;
                result  <= core_x1;
            end
            if (state == DONE && clear) begin
                {done, halted, timeout, pass, ld_err} <= '0;
                result <= '0;
                cycles <= '0;
            end
        end
    end
endmodule
